// File: rtl/ifetch_pkg.sv
// Shared types for the fetch stage: word typedefs, reset PC, fetch output entry and FSM states.
// No logic here beyond a small alignment helper.
package ifetch_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   instr;
        logic misalign;
    } fetch_data_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } ifetch_state_t;

    function automatic logic is_aligned(input u64 addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifetch.sv
// Fetch PC register + single-outstanding instruction-bus requester; instruction reaches f_* 1 cycle after data_ok.
// Backpressure: a held f_* entry blocks the next request until out_ready; redirect flushes held or in-flight fetches.
module ifetch
    import ifetch_pkg::*;
#(
    parameter u64 RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] pc_nxt,
    input  logic        redirect,
    input  logic        out_ready,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic [63:0] pcplus4,
    output logic        f_valid,
    output logic [63:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_misalign
);

    ifetch_state_t r_state;
    ifetch_state_t w_state_nxt;
    u64            r_pc;
    u64            w_pc_nxt;
    u64            r_req_addr;
    u64            w_req_addr_nxt;
    fetch_data_t   r_f;
    fetch_data_t   w_f_nxt;
    logic          w_aligned;

    assign w_aligned = is_aligned(r_pc);

    always_comb begin
        ireq_valid = ((r_state == REQ) && w_aligned) || (r_state == DROP);
        ireq_addr  = (r_state == DROP) ? r_req_addr : r_pc;
        pcplus4    = r_pc + 64'd4;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_f_nxt        = r_f;
        case (r_state)
            REQ: begin
                if (!w_aligned) begin
                    // Misaligned PC never reaches the bus; it becomes a fault entry unless redirected away.
                    w_pc_nxt = pc_nxt;
                    if (!redirect) begin
                        w_f_nxt     = '{valid: 1'b1, pc: r_pc, instr: '0, misalign: 1'b1};
                        w_state_nxt = HOLD;
                    end
                end else if (iresp_data_ok) begin
                    w_pc_nxt = pc_nxt;
                    if (!redirect) begin
                        w_f_nxt     = '{valid: 1'b1, pc: r_pc, instr: iresp_data, misalign: 1'b0};
                        w_state_nxt = HOLD;
                    end
                end else if (redirect) begin
                    // Keep driving the stale address until its response drains.
                    w_req_addr_nxt = r_pc;
                    w_pc_nxt       = pc_nxt;
                    w_state_nxt    = DROP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_f_nxt.valid = 1'b0;
                    w_pc_nxt      = pc_nxt;
                    w_state_nxt   = REQ;
                end else if (out_ready) begin
                    w_f_nxt.valid = 1'b0;
                    w_state_nxt   = REQ;
                end
            end
            DROP: begin
                if (redirect) begin
                    w_pc_nxt = pc_nxt;
                end
                if (iresp_data_ok) begin
                    w_state_nxt = REQ;
                end
            end
            default: begin
                w_state_nxt = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_f        <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            r_f        <= w_f_nxt;
        end
    end

    assign f_valid    = r_f.valid;
    assign f_pc       = r_f.pc;
    assign f_instr    = r_f.instr;
    assign f_misalign = r_f.misalign;

endmodule
